// File: rtl/fx_bus_pkg.sv
// fx_bus_pkg: shared definitions for the fx register bus arbiter.
//   FX_AW / FX_DW : default fx address / data widths
//   GNT0 / GNT1   : grant encodings (requester 0 / requester 1)
//   fx_state_t    : arbiter FSM state encoding
package fx_bus_pkg;

  localparam int FX_AW = 16;
  localparam int FX_DW = 8;

  localparam logic GNT0 = 1'b0;
  localparam logic GNT1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_RWAIT = 3'd3,
    ST_DONE  = 3'd4
  } fx_state_t;

endpackage

// File: rtl/fx_rr_arb2.sv
// fx_rr_arb2: two-input grant selector, purely combinational.
// Ports:
//   req0, req1 : pending requests
//   last_gnt   : requester granted most recently (GNT0/GNT1)
//   prio       : 1 = fixed priority (requester 0 wins contention), 0 = round robin
//   gnt        : selected requester (GNT0/GNT1), meaningful when valid
//   valid      : at least one request is pending
module fx_rr_arb2
  import fx_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  input  logic prio,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    gnt   = GNT0;
    if (req0 && req1) begin
      // On contention the requester that did not go last wins, unless
      // fixed priority is selected.
      gnt = prio ? GNT0 : ((last_gnt == GNT0) ? GNT1 : GNT0);
    end else if (req1) begin
      gnt = GNT1;
    end
  end

endmodule

// File: rtl/fx_bus_arbiter.sv
// fx_bus_arbiter: shares the fx register bus between the 485 command path
// (requester 0) and the local poller/status engine (requester 1). One
// single-byte write or read at a time; read data is sampled RD_LAT cycles
// after the fx_rd strobe and returned with a one-cycle ack.
//
// Build option: define FX_ARB_PRIO_EN for fixed priority (requester 0 always
// wins contention); default is round robin. Timing is the same in both modes.
//
// Ports:
//   clk_sys, rst_n          : clock, asynchronous active-low reset
//   reqN/wrN/addrN/wdataN   : requester N request (level), direction, address, data
//   ackN                    : requester N completion pulse (1 cycle)
//   rdataN                  : requester N read data, held until its next read completes
//   fx_wr/fx_waddr/fx_data  : fx write strobe, address, data
//   fx_rd/fx_raddr          : fx read strobe, address
//   fx_q                    : fx read data
//   busy                    : transaction in progress
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a request; arbitration and latching happen here
// ST_WR    | fx_wr strobe cycle
// ST_RD    | fx_rd strobe cycle
// ST_RWAIT | counting down the read latency, capture fx_q at lat_cnt==0
// ST_DONE  | ack pulse to the granted requester
module fx_bus_arbiter
  import fx_bus_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int AW     = FX_AW,
  parameter int DW     = FX_DW
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] fx_waddr,
  output logic          fx_wr,
  output logic [DW-1:0] fx_data,
  output logic          fx_rd,
  output logic [AW-1:0] fx_raddr,
  input  logic [DW-1:0] fx_q,
  output logic          busy
);

  localparam int              CW       = 4;
  localparam logic [CW-1:0]   LAT_LOAD = CW'(RD_LAT - 1);

  fx_state_t     state, state_nxt;
  logic          gnt_q;
  logic          last_gnt;
  logic [CW-1:0] lat_cnt;

  logic          prio_mode;
  logic          arb_gnt;
  logic          arb_valid;
  logic          grant;
  logic          capture;
  logic          wr_sel;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

`ifdef FX_ARB_PRIO_EN
  assign prio_mode = 1'b1;
`else
  assign prio_mode = 1'b0;
`endif

  fx_rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .prio     (prio_mode),
    .gnt      (arb_gnt),
    .valid    (arb_valid)
  );

  always_comb begin
    wr_sel    = wr0;
    addr_sel  = addr0;
    wdata_sel = wdata0;
    if (arb_gnt == GNT1) begin
      wr_sel    = wr1;
      addr_sel  = addr1;
      wdata_sel = wdata1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          grant     = 1'b1;
          state_nxt = wr_sel ? ST_WR : ST_RD;
        end
      end
      ST_WR:    state_nxt = ST_DONE;
      ST_RD:    state_nxt = ST_RWAIT;
      ST_RWAIT: begin
        if (lat_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and acks are registered from the next state so they line up
  // exactly with the WR/RD/DONE cycles without decode glitches. The fx
  // address/data registers double as the transaction latches: they are
  // loaded once at grant and then simply held.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= GNT0;
      last_gnt <= GNT1;
      lat_cnt  <= '0;
      fx_wr    <= 1'b0;
      fx_rd    <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      fx_waddr <= '0;
      fx_data  <= '0;
      fx_raddr <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      fx_wr <= (state_nxt == ST_WR);
      fx_rd <= (state_nxt == ST_RD);
      ack0  <= (state_nxt == ST_DONE) && (gnt_q == GNT0);
      ack1  <= (state_nxt == ST_DONE) && (gnt_q == GNT1);

      if (grant) begin
        gnt_q    <= arb_gnt;
        last_gnt <= arb_gnt;
        if (wr_sel) begin
          fx_waddr <= addr_sel;
          fx_data  <= wdata_sel;
        end else begin
          fx_raddr <= addr_sel;
        end
      end

      if (state == ST_RD) begin
        lat_cnt <= LAT_LOAD;
      end else if (state == ST_RWAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - CW'(1);
      end

      if (capture) begin
        if (gnt_q == GNT1) begin
          rdata1 <= fx_q;
        end else begin
          rdata0 <= fx_q;
        end
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
